// File: rtl/mc_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg : shared encodings for the multicycle controller, datapath, alucontrol
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_TRAP   = 4'd9
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] CZ_ALWAYS = 2'b00;
  localparam logic [1:0] CZ_ZERO   = 2'b01;
  localparam logic [1:0] CZ_CARRY  = 2'b10;
  localparam logic [1:0] CZ_BAD    = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] alu_op;
    logic       reg_we;
    logic       reg_dst;
    logic       wb_sel;
    logic       trap;
  } ctl_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_NAND);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_unit_if : decode fields, ALU status and datapath controls
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mc_ctrl_unit_if #(parameter int XLEN = 16);
  logic [3:0]      op;
  logic [1:0]      cz;
  logic [XLEN-1:0] alu_result;
  logic            alu_carry;
  logic            mem_ready;

  logic            mem_req;
  logic            mem_we;
  logic            iord;
  logic            ir_we;
  logic            pc_we;
  logic            pc_src;
  logic            alu_srca;
  logic [1:0]      alu_srcb;
  logic [1:0]      alu_op;
  logic            reg_we;
  logic            reg_dst;
  logic            wb_sel;
  logic            carry_flag;
  logic            zero_flag;
  logic            trap;
  logic [3:0]      state_o;

  modport master (
    input  op, cz, alu_result, alu_carry, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_srca, alu_srcb,
           alu_op, reg_we, reg_dst, wb_sel, carry_flag, zero_flag, trap, state_o
  );

  modport slave (
    output op, cz, alu_result, alu_carry, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_srca, alu_srcb,
           alu_op, reg_we, reg_dst, wb_sel, carry_flag, zero_flag, trap, state_o
  );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl_unit_mem_wait.sv
// ---------------------------------------------------------------------------
// mc_mem_wait : counts stalled memory request cycles and flags a timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_mem_wait #(
  parameter int TMO_CYCLES = 15,
  parameter int TWR        = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic req,
  input  wire logic ready,
  output logic      timeout
);

  localparam logic [TWR-1:0] LIMIT = TWR'(TMO_CYCLES - 1);

  logic [TWR-1:0] cnt_q, cnt_d;
  logic           waiting;

  // Any cycle without a stalled request clears the count, so each access starts at zero.
  always_comb begin
    waiting = req & ~ready;
    timeout = waiting && (cnt_q == LIMIT);
    cnt_d   = waiting ? cnt_q + TWR'(1) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// mc_ctrl_unit : multicycle NITC-RISC controller with flags, cond. writeback, trap
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_unit
  import mc_pkg::*;
#(
  parameter int XLEN       = 16,
  parameter int TMO_CYCLES = 15,
  parameter int TWR        = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mc_ctrl_unit_if.master  bus
);

  state_e state_q, state_d;
  logic   wb_en_q, wb_en_d;
  logic   carry_q, carry_d;
  logic   zero_q,  zero_d;
  ctl_t   ctl;
  logic   mem_state;
  logic   mem_timeout;
  logic   result_zero;

  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign result_zero = (bus.alu_result[XLEN-1:0] == '0);

  mc_mem_wait #(
    .TMO_CYCLES (TMO_CYCLES),
    .TWR        (TWR)
  ) u_mem_wait (
    .clk     (clk),
    .reset   (reset),
    .req     (mem_state),
    .ready   (bus.mem_ready),
    .timeout (mem_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wb_en_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_en_q <= wb_en_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wb_en_d = wb_en_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ctl     = '0;

    unique case (state_q)
      S_FETCH: begin
        ctl.mem_req  = 1'b1;
        ctl.alu_srcb = SRCB_ONE;
        ctl.alu_op   = ALU_ADD;
        if (bus.mem_ready) begin
          ctl.ir_we = 1'b1;
          ctl.pc_we = 1'b1;
          state_d   = S_DECODE;
        end else if (mem_timeout) begin
          state_d = S_TRAP;
        end
      end

      S_DECODE: begin
        ctl.alu_srcb = SRCB_IMM;
        ctl.alu_op   = ALU_ADD;
        // Condition resolved against the flags as they stand before this instruction.
        case (bus.cz)
          CZ_ALWAYS: wb_en_d = 1'b1;
          CZ_CARRY:  wb_en_d = carry_q;
          CZ_ZERO:   wb_en_d = zero_q;
          default:   wb_en_d = 1'b0;
        endcase
        if (is_alu_op(bus.op))
          state_d = (bus.cz == CZ_BAD) ? S_TRAP : S_EXEC;
        else if ((bus.op == OP_LW) || (bus.op == OP_SW))
          state_d = S_MEMADR;
        else if (bus.op == OP_BEQ)
          state_d = S_BEQ;
        else
          state_d = S_TRAP;
      end

      S_MEMADR: begin
        ctl.alu_srca = 1'b1;
        ctl.alu_srcb = SRCB_IMM;
        ctl.alu_op   = ALU_ADD;
        state_d      = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (mem_timeout) state_d = S_TRAP;
      end

      S_MEMWB: begin
        ctl.reg_we = 1'b1;
        ctl.wb_sel = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = 1'b1;
        ctl.iord    = 1'b1;
        if (bus.mem_ready)  state_d = S_FETCH;
        else if (mem_timeout) state_d = S_TRAP;
      end

      S_EXEC: begin
        ctl.alu_srca = 1'b1;
        ctl.alu_srcb = SRCB_B;
        ctl.alu_op   = (bus.op == OP_NAND) ? ALU_NAND : ALU_ADD;
        if (wb_en_q) begin
          zero_d = result_zero;
          if (bus.op == OP_ADD) carry_d = bus.alu_carry;
        end
        state_d = S_RWB;
      end

      S_RWB: begin
        ctl.reg_we  = wb_en_q;
        ctl.reg_dst = 1'b1;
        state_d     = S_FETCH;
      end

      S_BEQ: begin
        ctl.alu_srca = 1'b1;
        ctl.alu_srcb = SRCB_B;
        ctl.alu_op   = ALU_SUB;
        ctl.pc_src   = 1'b1;
        ctl.pc_we    = result_zero;
        state_d      = S_FETCH;
      end

      S_TRAP: begin
        ctl.trap = 1'b1;
      end

      default: state_d = S_TRAP;
    endcase

    // Controls are silenced while reset is held so no write escapes an aborted instruction.
    if (reset) ctl = '0;
  end

  assign bus.mem_req    = ctl.mem_req;
  assign bus.mem_we     = ctl.mem_we;
  assign bus.iord       = ctl.iord;
  assign bus.ir_we      = ctl.ir_we;
  assign bus.pc_we      = ctl.pc_we;
  assign bus.pc_src     = ctl.pc_src;
  assign bus.alu_srca   = ctl.alu_srca;
  assign bus.alu_srcb   = ctl.alu_srcb;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.reg_we     = ctl.reg_we;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.wb_sel     = ctl.wb_sel;
  assign bus.trap       = ctl.trap;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;
  assign bus.state_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_unit : randomized instruction stream against an instruction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mc_ctrl_unit;
  import mc_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_ctrl_unit_if #(.XLEN(16)) bus ();

  mc_ctrl_unit #(.XLEN(16), .TMO_CYCLES(TMO), .TWR(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit m_c, m_z;

  logic [13:0] ctl_en;
  assign ctl_en = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.pc_src,
                   bus.alu_srca, bus.alu_srcb, bus.alu_op, bus.reg_we, bus.reg_dst, bus.wb_sel};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    m_c = 1'b0;
    m_z = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state_o), 32'(S_FETCH));
    chk("rst_ctl",   32'({ctl_en, bus.trap, bus.carry_flag, bus.zero_flag}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_ctl", 32'({ctl_en, bus.trap, bus.carry_flag, bus.zero_flag}), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle; wf/wd are memory stall cycles.
  task automatic run_instr(input logic [3:0] op, input logic [1:0] cz, input logic [15:0] res,
                           input bit carry, input int wf, input int wd, input string tag);
    bit   is_alu = (op == OP_ADD) || (op == OP_NAND);
    bit   is_mem = (op == OP_LW) || (op == OP_SW);
    int   base   = (op == OP_BEQ) ? 3 : (op == OP_LW) ? 5 : 4;
    int   ncyc   = base + wf + (is_mem ? wd : 0);
    bit   wb     = !is_alu ? 1'b0 : (cz == 2'b00) ? 1'b1 : (cz == 2'b10) ? m_c : m_z;
    int   e_rw   = is_alu ? int'(wb) : int'(op == OP_LW);
    int   e_pc   = 1 + int'((op == OP_BEQ) && (res == 16'd0));
    int   e_req  = wf + 1 + (is_mem ? wd + 1 : 0);
    int   e_mw   = (op == OP_SW) ? wd + 1 : 0;
    int   e_rt   = (e_rw == 0) ? 0 : (op == OP_LW) ? 1 : 2;
    int   n_ir = 0, n_pc = 0, n_rw = 0, n_req = 0, n_mw = 0, n_tr = 0, rt = 0;
    int   waits[$];
    int   cur;

    if (is_alu && wb) begin
      m_z = (res == 16'd0);
      if (op == OP_ADD) m_c = carry;
    end

    bus.op         = op;
    bus.cz         = cz;
    bus.alu_result = res;
    bus.alu_carry  = carry;
    waits.push_back(wf);
    if (is_mem) waits.push_back(wd);
    cur = waits.pop_front();

    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (cur > 0) begin
          bus.mem_ready = 1'b0;
          cur--;
        end else begin
          bus.mem_ready = 1'b1;
          cur = (waits.size() > 0) ? waits.pop_front() : 0;
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (bus.ir_we)   n_ir++;
      if (bus.pc_we)   n_pc++;
      if (bus.mem_req) n_req++;
      if (bus.mem_we)  n_mw++;
      if (bus.trap)    n_tr++;
      if (bus.reg_we) begin
        n_rw++;
        rt = int'({bus.reg_dst, bus.wb_sel});
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_done"},  32'(bus.state_o), 32'(S_FETCH));
    chk({tag, "_ir_we"}, 32'(n_ir),  32'd1);
    chk({tag, "_pc_we"}, 32'(n_pc),  32'(e_pc));
    chk({tag, "_reg_we"},32'(n_rw),  32'(e_rw));
    chk({tag, "_route"}, 32'(rt),    32'(e_rt));
    chk({tag, "_req"},   32'(n_req), 32'(e_req));
    chk({tag, "_mem_we"},32'(n_mw),  32'(e_mw));
    chk({tag, "_trap"},  32'(n_tr),  32'd0);
    chk({tag, "_flags"}, 32'({bus.carry_flag, bus.zero_flag}), 32'({m_c, m_z}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] ops [5];
    int         tmo_at;
    int         rw_seen;
    logic [3:0] rop;
    logic [1:0] rcz;

    ops = '{OP_ADD, OP_NAND, OP_SW, OP_LW, OP_BEQ};
    bus.op = '0; bus.cz = '0; bus.alu_result = '0; bus.alu_carry = 1'b0; bus.mem_ready = 1'b0;

    do_reset();
    run_instr(OP_ADD,  2'b00, 16'h1234, 1'b0, 0, 0, "add");
    run_instr(OP_ADD,  2'b00, 16'h0000, 1'b1, 0, 0, "add_zc");
    run_instr(OP_ADD,  2'b10, 16'h0005, 1'b0, 0, 0, "adc_taken");
    run_instr(OP_ADD,  2'b10, 16'h0000, 1'b1, 0, 0, "adc_skip");
    run_instr(OP_NAND, 2'b01, 16'h00ff, 1'b1, 0, 0, "ndz_skip");
    run_instr(OP_LW,   2'b00, 16'h0007, 1'b0, 0, 3, "lw_wait3");
    run_instr(OP_SW,   2'b00, 16'h0009, 1'b0, 1, 2, "sw_wait");
    run_instr(OP_BEQ,  2'b00, 16'h0000, 1'b0, 0, 0, "beq_take");
    run_instr(OP_BEQ,  2'b00, 16'h0005, 1'b0, 0, 0, "beq_not");
    run_instr(OP_ADD,  2'b00, 16'h0001, 1'b0, TMO - 1, 0, "fetch_limit");
    run_instr(OP_LW,   2'b00, 16'h0003, 1'b0, 2, TMO - 1, "lw_limit");

    for (int i = 0; i < 150; i++) begin
      rop = ops[$urandom_range(0, 4)];
      rcz = is_alu_op(rop) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
      run_instr(rop, rcz,
                ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom),
                1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
    end

    // Illegal opcode traps from DECODE
    bus.op = 4'b0111; bus.cz = 2'b00; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("illegal_state", 32'(bus.state_o), 32'(S_TRAP));
    chk("illegal_trap",  32'(bus.trap), 32'd1);
    chk("illegal_ctl",   32'(ctl_en), 32'd0);

    do_reset();
    bus.op = OP_ADD; bus.cz = 2'b11; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("cz11_trap", 32'(bus.trap), 32'd1);

    // Fetch that never completes
    do_reset();
    bus.mem_ready = 1'b0;
    tmo_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.trap && tmo_at < 0) tmo_at = k;
    end
    chk("tmo_cycles", 32'(tmo_at), 32'(TMO));
    chk("tmo_ctl",    32'(ctl_en), 32'd0);
    chk("tmo_sticky", 32'(bus.trap), 32'd1);
    do_reset();
    chk("tmo_cleared", 32'(bus.trap), 32'd0);

    // Reset landing in EXEC aborts the instruction
    bus.op = OP_ADD; bus.cz = 2'b00; bus.alu_result = 16'h0000; bus.alu_carry = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("exec_reached", 32'(bus.state_o), 32'(S_EXEC));
    #2 reset = 1'b1;
    #1;
    chk("abort_state", 32'(bus.state_o), 32'(S_FETCH));
    chk("abort_ctl",   32'({ctl_en, bus.trap}), 32'd0);
    rw_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.reg_we) rw_seen++;
    end
    chk("abort_no_wb",  32'(rw_seen), 32'd0);
    chk("abort_flags",  32'({bus.carry_flag, bus.zero_flag}), 32'd0);
    m_c = 1'b0;
    m_z = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    run_instr(OP_ADD, 2'b00, 16'h0042, 1'b1, 0, 0, "post_abort");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
